// File: rtl/tick_timer_arbiter.sv
// Round-robin arbiter for two requesters sharing one programmable tick divider.
// The winner runs cnt divider periods of length dvsr (0 means 2^N) and then gets a done pulse.
module tick_timer_arbiter #(
  parameter int unsigned N = 8,
  parameter int unsigned C = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req,
  input  logic [N-1:0] dvsr0,
  input  logic [N-1:0] dvsr1,
  input  logic [C-1:0] cnt0,
  input  logic [C-1:0] cnt1,
  output logic [1:0]   grant,
  output logic         busy,
  output logic         tick,
  output logic [N-1:0] q,
  output logic [1:0]   done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t       r_state;
  logic [1:0]   r_grant;
  logic         r_busy;
  logic         r_tick;
  logic [N-1:0] r_q;
  logic [1:0]   r_done;
  logic [C-1:0] r_tcnt;
  logic         r_last;
  logic         r_idx;
  logic [N-1:0] r_dvsr;
  logic [C-1:0] r_cnt;

  logic         w_win;
  logic [1:0]   w_win_oh;
  logic [1:0]   w_idx_oh;
  logic [N-1:0] w_sel_dvsr;
  logic [C-1:0] w_sel_cnt;
  logic [N-1:0] w_dm1;
  logic         w_at_tc;
  logic [N-1:0] w_q_nxt;
  logic         w_last_tick;

  // A lone requester wins outright; on a tie the one not served last wins.
  always_comb begin
    w_win = ~r_last;
    if (req == 2'b01) begin
      w_win = 1'b0;
    end else if (req == 2'b10) begin
      w_win = 1'b1;
    end
  end

  assign w_win_oh   = w_win ? 2'b10 : 2'b01;
  assign w_idx_oh   = r_idx ? 2'b10 : 2'b01;
  assign w_sel_dvsr = w_win ? dvsr1 : dvsr0;
  assign w_sel_cnt  = w_win ? cnt1 : cnt0;

  // Terminal count is D-1 modulo 2^N, so a zero divisor naturally gives a 2^N period.
  assign w_dm1       = r_dvsr - N'(1);
  assign w_at_tc     = (r_q == w_dm1);
  assign w_q_nxt     = w_at_tc ? '0 : r_q + N'(1);
  assign w_last_tick = w_at_tc && (r_tcnt == r_cnt - C'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_tick  <= 1'b0;
      r_q     <= '0;
      r_done  <= '0;
      r_tcnt  <= '0;
      r_last  <= 1'b1;
      r_idx   <= 1'b0;
      r_dvsr  <= '0;
      r_cnt   <= '0;
    end else begin
      r_done <= '0;
      r_tick <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req != 2'b00) begin
            r_idx  <= w_win;
            r_dvsr <= w_sel_dvsr;
            r_cnt  <= w_sel_cnt;
            r_q    <= '0;
            r_tcnt <= '0;
            if (w_sel_cnt == '0) begin
              r_state <= S_DONE;
              r_done  <= w_win_oh;
            end else begin
              r_state <= S_RUN;
              r_grant <= w_win_oh;
              r_busy  <= 1'b1;
              r_tick  <= (w_sel_dvsr == N'(1));
            end
          end
        end
        S_RUN: begin
          if (!req[r_idx]) begin
            r_state <= S_IDLE;
            r_last  <= r_idx;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_q     <= '0;
          end else if (w_last_tick) begin
            r_state <= S_DONE;
            r_done  <= w_idx_oh;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_q     <= '0;
          end else begin
            r_q    <= w_q_nxt;
            r_tick <= (w_q_nxt == w_dm1);
            if (w_at_tc) begin
              r_tcnt <= r_tcnt + C'(1);
            end
          end
        end
        S_DONE: begin
          r_last  <= r_idx;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign grant = r_grant;
  assign busy  = r_busy;
  assign tick  = r_tick;
  assign q     = r_q;
  assign done  = r_done;

endmodule

// File: tb/tb_tick_timer_arbiter.sv
// Bench for tick_timer_arbiter: job-level reference model checked every cycle,
// plus directed scenarios with hand-computed cycle expectations.
module tb_tick_timer_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned C = 4;
  localparam int unsigned W = N + 6;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req;
  logic [N-1:0] dvsr0, dvsr1;
  logic [C-1:0] cnt0, cnt1;
  logic [1:0]   grant;
  logic         busy;
  logic         tick;
  logic [N-1:0] q;
  logic [1:0]   done;

  int n_checks = 0;
  int n_pass   = 0;

  tick_timer_arbiter #(.N(N), .C(C)) dut (
    .clk(clk), .reset(reset), .req(req),
    .dvsr0(dvsr0), .dvsr1(dvsr1), .cnt0(cnt0), .cnt1(cnt1),
    .grant(grant), .busy(busy), .tick(tick), .q(q), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a job is described by its owner, period D and total length D*cnt.
  bit m_valid  = 1'b0;
  bit m_active = 1'b0;
  bit m_donep  = 1'b0;
  bit m_last   = 1'b1;
  bit m_idx    = 1'b0;
  int m_d      = 1;
  int m_total  = 0;
  int m_el     = 0;

  function automatic bit pick(input logic [1:0] r, input bit last);
    if (r == 2'b11) return !last;
    return r[1];
  endfunction

  function automatic int per(input logic [N-1:0] dv);
    if (dv == '0) return 1 << N;
    return int'(dv);
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_valid  <= 1'b1;
      m_active <= 1'b0;
      m_donep  <= 1'b0;
      m_last   <= 1'b1;
    end else if (m_valid) begin
      if (m_donep) begin
        m_donep <= 1'b0;
        m_last  <= m_idx;
      end else if (m_active) begin
        if (!req[m_idx]) begin
          m_active <= 1'b0;
          m_last   <= m_idx;
        end else if (m_el + 1 == m_total) begin
          m_active <= 1'b0;
          m_donep  <= 1'b1;
        end else begin
          m_el <= m_el + 1;
        end
      end else if (req != 2'b00) begin
        m_idx   <= pick(req, m_last);
        m_d     <= pick(req, m_last) ? per(dvsr1) : per(dvsr0);
        m_total <= pick(req, m_last) ? per(dvsr1) * int'(cnt1) : per(dvsr0) * int'(cnt0);
        m_el    <= 0;
        if ((pick(req, m_last) ? cnt1 : cnt0) == '0) m_donep <= 1'b1;
        else m_active <= 1'b1;
      end
    end
  end

  function automatic logic [W-1:0] model_out();
    logic [1:0] oh;
    int ph;
    oh = m_idx ? 2'b10 : 2'b01;
    ph = m_el % m_d;
    if (m_active) return {oh, 1'b1, (ph == m_d - 1), N'(ph), 2'b00};
    if (m_donep)  return {2'b00, 1'b0, 1'b0, {N{1'b0}}, oh};
    return '0;
  endfunction

  always @(negedge clk) begin
    if (m_valid) check("model", 32'({grant, busy, tick, q, done}), 32'(model_out()));
  end

  logic [7:0]  hist8;
  logic [1:0]  gseq [4];
  logic [1:0]  last_g;
  logic [1:0]  prev_g;
  int          ng;
  int          t1, t2;
  bit          seen;

  initial begin
    reset = 1'b0; req = 2'b00;
    dvsr0 = '0; dvsr1 = '0; cnt0 = '0; cnt1 = '0;
    @(negedge clk); @(negedge clk);
    check("reset_outs", 32'({grant, busy, tick, q, done}), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Single job, dvsr0=3 cnt0=2; mid-run input changes must be ignored.
    dvsr0 = 4'd3; cnt0 = 4'd2; req = 2'b01;
    hist8 = '0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      hist8[k] = tick;
      if (k == 1) check("t1_grant_c1", 32'(grant), 32'h1);
      if (k == 2) begin dvsr0 = 4'd7; cnt0 = 4'd9; end
      if (k == 7) begin
        check("t1_done_c7", 32'(done), 32'h1);
        check("t1_grant_c7", 32'(grant), 32'h0);
        req = 2'b00;
      end
    end
    check("t1_ticks", 32'(hist8), 32'h48);
    @(negedge clk); @(negedge clk);

    // Contention held from reset: grants alternate, done matches grant.
    dvsr0 = 4'd2; cnt0 = 4'd1; dvsr1 = 4'd2; cnt1 = 4'd1;
    reset = 1'b0; req = 2'b11;
    @(negedge clk);
    reset = 1'b1;
    ng = 0; prev_g = 2'b00; last_g = 2'b00;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (grant != 2'b00 && prev_g == 2'b00) begin
        if (ng < 4) gseq[ng] = grant;
        ng++;
        last_g = grant;
      end
      if (done != 2'b00) check("t2_done_owner", 32'(done), 32'(last_g));
      prev_g = grant;
    end
    check("t2_ngrants", 32'(ng >= 4), 32'h1);
    check("t2_g0", 32'(gseq[0]), 32'h1);
    check("t2_g1", 32'(gseq[1]), 32'h2);
    check("t2_g2", 32'(gseq[2]), 32'h1);
    check("t2_g3", 32'(gseq[3]), 32'h2);
    req = 2'b00;
    repeat (4) @(negedge clk);

    // D=1: tick on every run cycle, done at t+5.
    dvsr0 = 4'd1; cnt0 = 4'd4; req = 2'b01;
    hist8 = '0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      hist8[k] = tick;
      if (k == 5) begin check("t3_done_c5", 32'(done), 32'h1); req = 2'b00; end
    end
    check("t3_ticks", 32'(hist8), 32'h1e);
    @(negedge clk); @(negedge clk);

    // D=0 with N=4: period 16.
    dvsr0 = 4'd0; cnt0 = 4'd2; req = 2'b01;
    t1 = 0; t2 = 0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (tick) begin
        if (t1 == 0) t1 = k;
        else if (t2 == 0) t2 = k;
      end
      if (k == 33) begin check("t4_done_c33", 32'(done), 32'h1); req = 2'b00; end
    end
    check("t4_tick1", 32'(t1), 32'd16);
    check("t4_tick2", 32'(t2), 32'd32);
    @(negedge clk); @(negedge clk);

    // cnt=0: immediate done, never busy.
    dvsr0 = 4'd3; cnt0 = 4'd0; req = 2'b01;
    seen = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) begin check("t5_done_c1", 32'(done), 32'h1); req = 2'b00; end
      seen = seen | busy | (grant != 2'b00);
    end
    check("t5_never_busy", 32'(seen), 32'h0);

    // Abort requester 0 mid-run; pending requester 1 granted a cycle later.
    dvsr0 = 4'd3; cnt0 = 4'd3; dvsr1 = 4'd2; cnt1 = 4'd1; req = 2'b01;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 2) req = 2'b10;
      if (k == 3) begin
        check("t6_grant_c3", 32'(grant), 32'h0);
        check("t6_nodone_c3", 32'(done), 32'h0);
      end
      if (k == 4) check("t6_grant_c4", 32'(grant), 32'h2);
      if (k == 6) begin check("t6_done_c6", 32'(done), 32'h2); req = 2'b00; end
    end
    @(negedge clk); @(negedge clk);

    // Reset mid-run, then requester 0 wins the first tie.
    dvsr0 = 4'd5; cnt0 = 4'd3; req = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 3) begin reset = 1'b0; req = 2'b11; end
      if (k == 4) begin
        check("t7_outs_zero", 32'({grant, busy, tick, q, done}), 32'h0);
        reset = 1'b1;
      end
      if (k == 5) begin check("t7_grant_c5", 32'(grant), 32'h1); req = 2'b00; end
    end
    repeat (3) @(negedge clk);

    // Maximum tick count completes.
    dvsr0 = 4'd1; cnt0 = 4'd15; req = 2'b01;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 16) begin check("t8_done_c16", 32'(done), 32'h1); req = 2'b00; end
    end
    @(negedge clk); @(negedge clk);

    // Holding req after done re-requests in the following idle cycle.
    dvsr0 = 4'd2; cnt0 = 4'd1; req = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 3) check("t9_done_c3", 32'(done), 32'h1);
      if (k == 5) begin check("t9_regrant_c5", 32'(grant), 32'h1); req = 2'b00; end
    end
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tick_timer_arbiter.md
TICK_TIMER_ARBITER -- requirements
Module: tick_timer_arbiter

Interface
REQ-001 Parameter N, default 8: divisor width in bits.
REQ-002 Parameter C, default 8: tick-count width in bits.
REQ-003 The block SHALL have exactly one clock domain, and reset SHALL be synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-low reset (0 = reset), sampled on clk rising edge.
REQ-006 req  input  2  level request, one bit per requester (bit 0, bit 1).
REQ-007 dvsr0, dvsr1  input  N each  divisor per requester; a value of 0 SHALL mean 2^N.
REQ-008 cnt0, cnt1  input  C each  number of divider ticks per requester.
REQ-009 grant  output  2  one-hot owner of the shared divider, or 0.
REQ-010 busy  output  1  high in RUN.
REQ-011 tick  output  1  divider terminal-count pulse of the active job.
REQ-012 q  output  N  current divider count.
REQ-013 done  output  2  one-cycle completion pulse to the served requester.

Function
REQ-014 States SHALL be IDLE, RUN and DONE; reset SHALL enter IDLE.
REQ-015 In IDLE with req != 0, the block SHALL select a winner, latch the winner's dvsr, cnt and index, and enter RUN on the next cycle, unless the latched cnt == 0 (see REQ-021).
REQ-016 Arbitration SHALL be round-robin:
- single requester: that requester wins;
- both requesting: the requester not served last wins;
- the last-served pointer SHALL reset to 1, so requester 0 wins the first tie.
REQ-017 Inputs dvsr and cnt SHALL be sampled only at selection; changes during RUN SHALL be ignored.
REQ-018 In RUN:
- grant[idx] = 1 and busy = 1;
- the divider SHALL count 0..D-1 and wrap to 0, where D is the latched divisor;
- tick SHALL be 1 when the count equals D-1, computed modulo 2^N;
- a tick counter SHALL increment on each tick.
REQ-019 On the tick where the tick counter equals cnt-1, the block SHALL enter DONE.
REQ-020 Latency: with req sampled in IDLE at cycle t, grant SHALL rise at t+1 and done SHALL pulse at cycle t+1+D*cnt.
REQ-021 If the latched cnt == 0, the block SHALL go from IDLE directly to DONE with no RUN cycles, and done SHALL pulse at t+1.
REQ-022 In DONE:
- done[idx] = 1 for exactly one cycle;
- grant = 0 and busy = 0;
- the last-served pointer SHALL be set to idx;
- the next state SHALL be IDLE.
REQ-023 Abort: if req[idx] is 0 in any RUN cycle, the block SHALL return to IDLE on the next cycle with no done pulse and SHALL set the last-served pointer to idx.
REQ-024 A requester holding req high after done SHALL be treated as a new request in the following IDLE cycle.
REQ-025 Arbitration takes effect only in IDLE: a req rising during RUN or DONE SHALL wait, with no preemption.
REQ-026 Outside RUN, q = 0 and tick = 0; the divider and tick counter SHALL be cleared on entry to RUN.
REQ-027 D == 1 SHALL give tick on every RUN cycle; D == 0 SHALL give a period of 2^N cycles.
REQ-028 Tick-counter width SHALL be C, and cnt == 2^C - 1 SHALL complete without overflow.

Reset
REQ-029 With reset == 0 at a rising edge, on the next cycle:
- state = IDLE;
- grant = 0, busy = 0, tick = 0, done = 0, q = 0;
- tick counter = 0;
- last-served pointer = 1.
REQ-030 Reset asserted mid-RUN SHALL abort the job silently, with no done pulse.
REQ-031 Reset SHALL override every other input in the same cycle.

Verification
REQ-032 Single job: req=01, dvsr0=3, cnt0=2, req seen at cycle 0 -> grant=01 at cycle 1; tick at cycles 3 and 6; done=01 at cycle 7; grant=00 at cycle 7.
REQ-033 Contention: req=11 held from reset -> grant sequence 01, 10, 01, 10, with each done matching its grant.
REQ-034 Degenerate divisors:
- dvsr0=1, cnt0=4 -> tick on 4 consecutive RUN cycles, done at t+5;
- dvsr0=0, N=4 -> tick every 16 cycles.
REQ-035 cnt0=0 -> done=01 at t+1; busy and grant never assert.
REQ-036 Abort: drop req[0] mid-RUN -> IDLE next cycle, no done; a pending req[1] SHALL be granted in the cycle after.
REQ-037 Reset in RUN with dvsr0=5, cnt0=3 -> all outputs 0 the next cycle; after reset release with both requesting, requester 0 SHALL win.
